// File: rtl/seq_match_monitor_pkg.sv
// seq_mon_pkg
//   Shared types and helpers for the sequence-match monitor.
//   state_t  : monitor FSM encoding (2'd3 is unused and recovers to S_IDLE)
//   sat_inc  : saturating add of `inc` to `value`, clamped to 2**width-1
package seq_mon_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_LOCKED = 2'd2
    } state_t;

    // Works for widths 1..32; the 33-bit sum keeps the carry so a full
    // 32-bit counter still clamps instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                            input logic [31:0] inc,
                                            input int unsigned width);
        logic [32:0] sum;
        logic [32:0] max;
        max = (33'd1 << width) - 33'd1;
        sum = {1'b0, value} + {1'b0, inc};
        if (sum > max) begin
            sum = max;
        end
        return sum[31:0];
    endfunction

endpackage

// File: rtl/seq_match_monitor_if.sv
// seq_match_monitor_if
//   Control/status bundle of the sequence-match monitor.
//   Inputs to the monitor : en, match, clr, alarm_ack
//   Outputs of the monitor: win_count[CNT_W], win_valid, alarm,
//                           total_count[TOT_W], active, locked
//   master : the side driving the controls (software / detector side)
//   slave  : the monitor itself
interface seq_match_monitor_if #(
    parameter int unsigned CNT_W = 8,
    parameter int unsigned TOT_W = 16
);
    logic             en;
    logic             match;
    logic             clr;
    logic             alarm_ack;
    logic [CNT_W-1:0] win_count;
    logic             win_valid;
    logic             alarm;
    logic [TOT_W-1:0] total_count;
    logic             active;
    logic             locked;

    modport master (
        output en, match, clr, alarm_ack,
        input  win_count, win_valid, alarm, total_count, active, locked
    );

    modport slave (
        input  en, match, clr, alarm_ack,
        output win_count, win_valid, alarm, total_count, active, locked
    );
endinterface

// File: rtl/seq_match_monitor_sat_cnt.sv
// seq_sat_cnt
//   Synchronous saturating up-counter; holds at 2**W-1 and never wraps.
//   clk : clock (posedge)
//   rst : synchronous active-high reset to 0
//   clr : synchronous clear to 0 (wins over inc)
//   inc : add one this cycle
//   out : current count [W]
module seq_sat_cnt
    import seq_mon_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] out
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            out <= '0;
        end else if (inc) begin
            out <= W'(sat_inc(32'(out), 32'd1, W));
        end
    end

endmodule

// File: rtl/seq_match_monitor.sv
// seq_match_monitor
//   Counts detector match pulses over back-to-back windows of WIN_LEN cycles,
//   publishes each window's count, raises a sticky alarm when a window count
//   reaches THRESH, and keeps a saturating lifetime total. With
//   LOCK_ON_ALARM=1 counting stops on alarm until alarm_ack.
//   clk : clock (posedge)
//   rst : synchronous active-high reset
//   bus : seq_match_monitor_if.slave
//         in : en, match, clr, alarm_ack
//         out: win_count, win_valid, alarm, total_count, active, locked
module seq_match_monitor
    import seq_mon_pkg::*;
#(
    parameter int unsigned WIN_LEN       = 16,
    parameter int unsigned CNT_W         = 8,
    parameter int unsigned THRESH        = 4,
    parameter int unsigned TOT_W         = 16,
    parameter bit          LOCK_ON_ALARM = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    seq_match_monitor_if.slave  bus
);

    localparam int unsigned BC_W = $clog2(WIN_LEN);
    localparam logic [BC_W-1:0] LAST_CYC = BC_W'(WIN_LEN - 1);

    state_t           state, state_nx;
    logic [BC_W-1:0]  bit_cnt, bit_cnt_nx;
    logic [CNT_W-1:0] win_acc;
    logic [CNT_W-1:0] win_final;
    logic [CNT_W-1:0] win_count;
    logic [TOT_W-1:0] total_count;
    logic             win_valid;
    logic             alarm;
    logic             acc_clr;
    logic             cnt_en;
    logic             win_upd;
    logic             alarm_set;

    // Window total including this cycle's match, used on the last window cycle.
    assign win_final = CNT_W'(sat_inc(32'(win_acc), 32'(bus.match), CNT_W));

    always_comb begin
        state_nx   = state;
        bit_cnt_nx = bit_cnt;
        acc_clr    = 1'b0;
        cnt_en     = 1'b0;
        win_upd    = 1'b0;
        alarm_set  = 1'b0;
        unique case (state)
            S_IDLE: begin
                acc_clr    = 1'b1;
                bit_cnt_nx = '0;
                if (bus.en) begin
                    state_nx = S_RUN;
                end
            end
            S_RUN: begin
                if (bus.clr || !bus.en) begin
                    // Partial window discarded; clr keeps running unless en drops.
                    acc_clr    = 1'b1;
                    bit_cnt_nx = '0;
                    state_nx   = bus.en ? S_RUN : S_IDLE;
                end else begin
                    cnt_en = 1'b1;
                    if (bit_cnt == LAST_CYC) begin
                        win_upd    = 1'b1;
                        acc_clr    = 1'b1;
                        bit_cnt_nx = '0;
                        if (win_final >= CNT_W'(THRESH)) begin
                            alarm_set = 1'b1;
                            if (LOCK_ON_ALARM) begin
                                state_nx = S_LOCKED;
                            end
                        end
                    end else begin
                        bit_cnt_nx = bit_cnt + 1'b1;
                    end
                end
            end
            S_LOCKED: begin
                acc_clr    = 1'b1;
                bit_cnt_nx = '0;
                if (bus.clr || bus.alarm_ack || !bus.en) begin
                    state_nx = bus.en ? S_RUN : S_IDLE;
                end
            end
            default: begin
                acc_clr    = 1'b1;
                bit_cnt_nx = '0;
                state_nx   = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            bit_cnt <= '0;
        end else begin
            state   <= state_nx;
            bit_cnt <= bit_cnt_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || bus.clr) begin
            win_count <= '0;
            win_valid <= 1'b0;
        end else begin
            win_valid <= win_upd;
            if (win_upd) begin
                win_count <= win_final;
            end
        end
    end

    // A set on the same edge as an ack wins, so the alarm is never lost.
    always_ff @(posedge clk) begin
        if (rst || bus.clr) begin
            alarm <= 1'b0;
        end else if (alarm_set) begin
            alarm <= 1'b1;
        end else if (bus.alarm_ack) begin
            alarm <= 1'b0;
        end
    end

    seq_sat_cnt #(.W(CNT_W)) u_win_acc (
        .clk (clk),
        .rst (rst),
        .clr (acc_clr),
        .inc (cnt_en & bus.match),
        .out (win_acc)
    );

    seq_sat_cnt #(.W(TOT_W)) u_total (
        .clk (clk),
        .rst (rst),
        .clr (bus.clr),
        .inc (cnt_en & bus.match),
        .out (total_count)
    );

    assign bus.win_count   = win_count;
    assign bus.win_valid   = win_valid;
    assign bus.alarm       = alarm;
    assign bus.total_count = total_count;
    assign bus.active      = (state != S_IDLE);
    assign bus.locked      = (state == S_LOCKED);

endmodule

// File: tb/tb_seq_match_monitor.sv
// tb_seq_match_monitor
//   Directed bench for seq_match_monitor with three instances:
//   dut_a default parameters (locking), dut_b CNT_W=3/TOT_W=4 non-locking,
//   dut_c default widths non-locking.
module tb_seq_match_monitor;

    logic clk;
    logic rst;
    int unsigned n_total;
    int unsigned n_bad;

    seq_match_monitor_if #(.CNT_W(8), .TOT_W(16)) ifa ();
    seq_match_monitor_if #(.CNT_W(3), .TOT_W(4))  ifb ();
    seq_match_monitor_if #(.CNT_W(8), .TOT_W(16)) ifc ();

    seq_match_monitor #(.WIN_LEN(16), .CNT_W(8), .THRESH(4), .TOT_W(16), .LOCK_ON_ALARM(1'b1))
        dut_a (.clk(clk), .rst(rst), .bus(ifa));
    seq_match_monitor #(.WIN_LEN(16), .CNT_W(3), .THRESH(4), .TOT_W(4), .LOCK_ON_ALARM(1'b0))
        dut_b (.clk(clk), .rst(rst), .bus(ifb));
    seq_match_monitor #(.WIN_LEN(16), .CNT_W(8), .THRESH(4), .TOT_W(16), .LOCK_ON_ALARM(1'b0))
        dut_c (.clk(clk), .rst(rst), .bus(ifc));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full 16-cycle window; mpat[k] is the match on window cycle k.
    task automatic win_a(input logic [15:0] mpat, input string nm);
        for (int k = 0; k < 16; k++) begin
            ifa.match = mpat[k];
            tick();
            chk($sformatf("%s.wv%0d", nm, k), 32'(ifa.win_valid), 32'(k == 15));
        end
        ifa.match = 1'b0;
    endtask

    task automatic win_b(input logic [15:0] mpat, input string nm);
        for (int k = 0; k < 16; k++) begin
            ifb.match = mpat[k];
            tick();
            chk($sformatf("%s.wv%0d", nm, k), 32'(ifb.win_valid), 32'(k == 15));
        end
        ifb.match = 1'b0;
    endtask

    task automatic win_c(input logic [15:0] mpat, input logic [15:0] apat, input string nm);
        for (int k = 0; k < 16; k++) begin
            ifc.match     = mpat[k];
            ifc.alarm_ack = apat[k];
            tick();
            chk($sformatf("%s.wv%0d", nm, k), 32'(ifc.win_valid), 32'(k == 15));
        end
        ifc.match     = 1'b0;
        ifc.alarm_ack = 1'b0;
    endtask

    initial begin
        n_total = 0;
        n_bad   = 0;
        rst = 1'b1;
        ifa.en = 1'b0; ifa.match = 1'b0; ifa.clr = 1'b0; ifa.alarm_ack = 1'b0;
        ifb.en = 1'b0; ifb.match = 1'b0; ifb.clr = 1'b0; ifb.alarm_ack = 1'b0;
        ifc.en = 1'b0; ifc.match = 1'b0; ifc.clr = 1'b0; ifc.alarm_ack = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        chk("rst.win_count", 32'(ifa.win_count), 0);
        chk("rst.win_valid", 32'(ifa.win_valid), 0);
        chk("rst.alarm", 32'(ifa.alarm), 0);
        chk("rst.total", 32'(ifa.total_count), 0);
        chk("rst.active", 32'(ifa.active), 0);
        chk("rst.locked", 32'(ifa.locked), 0);

        // Test 1: matches on window cycles 2, 7, 15
        ifa.en = 1'b1;
        ifa.match = 1'b1;              // entry cycle: ignored
        tick();
        chk("t1.active", 32'(ifa.active), 1);
        chk("t1.total0", 32'(ifa.total_count), 0);
        win_a(16'h8084, "t1");
        chk("t1.win_count", 32'(ifa.win_count), 3);
        chk("t1.alarm", 32'(ifa.alarm), 0);
        chk("t1.total", 32'(ifa.total_count), 3);

        // Test 4: two matches, en dropped on window cycle 9
        for (int k = 0; k < 9; k++) begin
            ifa.match = (k == 1 || k == 4);
            tick();
            chk($sformatf("t4.wv%0d", k), 32'(ifa.win_valid), 0);
        end
        ifa.en = 1'b0;
        ifa.match = 1'b1;              // not counted
        tick();
        chk("t4.idle", 32'(ifa.active), 0);
        chk("t4.wv_drop", 32'(ifa.win_valid), 0);
        chk("t4.total", 32'(ifa.total_count), 5);
        tick();
        chk("t4.total_idle", 32'(ifa.total_count), 5);
        ifa.en = 1'b1;                 // re-entry, match still high and ignored
        tick();
        chk("t4.reentry", 32'(ifa.active), 1);
        chk("t4.total_entry", 32'(ifa.total_count), 5);
        win_a(16'h0000, "t4w");
        chk("t4.win_count", 32'(ifa.win_count), 0);
        chk("t4.total_end", 32'(ifa.total_count), 5);

        // Test 2: four matches, last on cycle 15 -> alarm + lock
        win_a(16'h8109, "t2");
        chk("t2.win_count", 32'(ifa.win_count), 4);
        chk("t2.alarm", 32'(ifa.alarm), 1);
        chk("t2.locked", 32'(ifa.locked), 1);
        chk("t2.total", 32'(ifa.total_count), 9);
        ifa.match = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("t2.lk_total%0d", k), 32'(ifa.total_count), 9);
            chk($sformatf("t2.lk_wv%0d", k), 32'(ifa.win_valid), 0);
            chk($sformatf("t2.lk_locked%0d", k), 32'(ifa.locked), 1);
        end
        ifa.match = 1'b0;
        ifa.alarm_ack = 1'b1;
        tick();
        ifa.alarm_ack = 1'b0;
        chk("t2.ack_alarm", 32'(ifa.alarm), 0);
        chk("t2.ack_locked", 32'(ifa.locked), 0);
        chk("t2.ack_active", 32'(ifa.active), 1);
        win_a(16'h0020, "t2b");
        chk("t2b.win_count", 32'(ifa.win_count), 1);
        chk("t2b.total", 32'(ifa.total_count), 10);
        chk("t2b.alarm", 32'(ifa.alarm), 0);

        // Test 3: narrow counters, match held high
        ifb.en = 1'b1;
        ifb.match = 1'b1;
        tick();
        chk("t3.active", 32'(ifb.active), 1);
        win_b(16'hFFFF, "t3a");
        chk("t3a.win_count", 32'(ifb.win_count), 7);
        chk("t3a.total", 32'(ifb.total_count), 15);
        chk("t3a.alarm", 32'(ifb.alarm), 1);
        chk("t3a.locked", 32'(ifb.locked), 0);
        win_b(16'hFFFF, "t3b");
        chk("t3b.win_count", 32'(ifb.win_count), 7);
        chk("t3b.total", 32'(ifb.total_count), 15);
        ifb.en = 1'b0;

        // Test 5: non-locking, ack coincides with a new alarm set
        ifc.en = 1'b1;
        tick();
        win_c(16'h000F, 16'h0000, "t5a");
        chk("t5a.win_count", 32'(ifc.win_count), 4);
        chk("t5a.alarm", 32'(ifc.alarm), 1);
        chk("t5a.locked", 32'(ifc.locked), 0);
        chk("t5a.total", 32'(ifc.total_count), 4);
        win_c(16'h001F, 16'h8000, "t5b");
        chk("t5b.win_count", 32'(ifc.win_count), 5);
        chk("t5b.alarm_set_wins", 32'(ifc.alarm), 1);
        chk("t5b.total", 32'(ifc.total_count), 9);
        win_c(16'h0001, 16'h0001, "t5c");
        chk("t5c.win_count", 32'(ifc.win_count), 1);
        chk("t5c.alarm", 32'(ifc.alarm), 0);
        chk("t5c.total", 32'(ifc.total_count), 10);
        chk("t5c.active", 32'(ifc.active), 1);
        ifc.en = 1'b0;

        // Test 6: clr mid-window restarts the window; then rst while locked
        for (int k = 0; k < 6; k++) begin
            ifa.match = (k < 3);
            tick();
        end
        chk("t6.pre_total", 32'(ifa.total_count), 13);
        ifa.clr = 1'b1;
        ifa.match = 1'b1;              // dropped
        tick();
        ifa.clr = 1'b0;
        ifa.match = 1'b0;
        chk("t6.clr_win_count", 32'(ifa.win_count), 0);
        chk("t6.clr_total", 32'(ifa.total_count), 0);
        chk("t6.clr_alarm", 32'(ifa.alarm), 0);
        chk("t6.clr_active", 32'(ifa.active), 1);
        chk("t6.clr_wv", 32'(ifa.win_valid), 0);
        win_a(16'h000F, "t6");
        chk("t6.win_count", 32'(ifa.win_count), 4);
        chk("t6.total", 32'(ifa.total_count), 4);
        chk("t6.alarm", 32'(ifa.alarm), 1);
        chk("t6.locked", 32'(ifa.locked), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6.rst_win_count", 32'(ifa.win_count), 0);
        chk("t6.rst_total", 32'(ifa.total_count), 0);
        chk("t6.rst_alarm", 32'(ifa.alarm), 0);
        chk("t6.rst_active", 32'(ifa.active), 0);
        chk("t6.rst_locked", 32'(ifa.locked), 0);
        chk("t6.rst_wv", 32'(ifa.win_valid), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
